pokey_voice_bank: RTL and testbench
===================================

POKEY_VOICE_BANK -- requirements
Module: pokey_voice_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, number of voice channels (2..8, even).
REQ-002 SHALL have parameter CW, default 8, frequency counter width (8..16).
REQ-003 SHALL have parameter PRE, default 57, clk_i cycles per base tick (2..255).
REQ-004 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port we_i  in  1  register write strobe.
REQ-007 SHALL have port adr_i  in  $clog2(NCH)+1  {channel, sel}; sel 0 = AUDF, 1 = AUDC.
REQ-008 SHALL have port dat_i  in  16  write data; AUDF uses [CW-1:0], AUDC uses [11:0].
REQ-009 SHALL have port dat_o  out  16  combinational readback of addressed register, zero-extended.
REQ-010 SHALL have port busy_o  out  NCH  per-channel counter running.
REQ-011 SHALL have port done_o  out  NCH  one-cycle pulse at one-shot expiry.
REQ-012 SHALL have port audout  out  4+$clog2(NCH)  registered mix of all channels.

Function
REQ-013 Base tick SHALL assert for one cycle every PRE cycles, from a prescaler counting 0..PRE-1; tick when the prescaler is at PRE-1.
REQ-014 AUDC fields: [3:0] vol, [4] vol_only, [5] pure (toggle), [6] poly4_sel, [7] no_poly5, [8] link, [9] fast, [10] oneshot, [11] hpf.
REQ-015 Channel clock enable: fast = 1 -> every cycle; link = 1 and odd channel -> borrow of channel i-1; otherwise base tick. link on even channels SHALL be ignored.
REQ-016 On enable with count == 0: count <= freq, borrow = 1 for that cycle; otherwise count <= count-1 on enable. Arithmetic is modulo 2^CW.
REQ-017 AUDF write: freq <= dat_i[CW-1:0], count <= dat_i[CW-1:0], nf <= 0, busy <= 1, same cycle.
REQ-018 AUDF write coinciding with an enable SHALL take priority; the decrement is lost.
REQ-019 On borrow and (no_poly5 or poly5): nf <= ~nf if pure, else poly4 if poly4_sel, else poly17.
REQ-020 oneshot = 1: at first borrow after AUDF write, busy <= 0, done_o pulses, counter holds at 0, nf frozen until next AUDF write. oneshot = 0: busy stays 1.
REQ-021 Channel level = vol when (vol_only or ch_out), else 0; ch_out = nf, or nf XOR hp when filtered.
REQ-022 Poly generators shared, advance every cycle, XNOR feedback: poly4 taps 3,2; poly5 taps 4,2; poly17 taps 16,11; output = MSB.
REQ-023 audout <= sum of all channel levels, one cycle latency, no saturation (width sufficient).
REQ-024 Writes to AUDC SHALL not disturb count, freq or nf.

Reset
REQ-025 rst_i SHALL clear prescaler, freq, count, AUDC, nf, hp, busy, all poly registers to 0; audout = 0, done_o = 0, busy_o = 0.
REQ-026 rst_i asserted mid-count SHALL abort immediately; no done_o pulse issued.

Configuration
REQ-027 Macro POKEY_VOICE_HPF_EN defined: channel i < NCH-2 with hpf = 1 has hp <= nf(i) on borrow of channel i+2; hp held 0 when hpf = 0.
REQ-028 Macro absent: AUDC[11] SHALL not be stored, reads 0, ch_out = nf always.

Structure
REQ-029 Package pokey_pkg SHALL hold AUDC bit-index constants, poly tap constants and the AUDF/AUDC sel encodings.
REQ-030 One sub-module pokey_voice (counter, nf, one-shot, level) SHALL be instantiated NCH times via generate; prescaler, polys and mixer live in the top.

Verification
REQ-031 NCH=4, AUDF0=3, AUDC0=0x2AF (pure, fast, vol 15) -> nf0 toggles every 4 cycles; audout alternates 0/15.
REQ-032 AUDC0=0x01F (vol_only, vol 15), AUDC1=0x018 (vol 8) -> audout = 23 one cycle after the writes.
REQ-033 AUDC0=0x6AF (oneshot, fast), AUDF0=5 -> done_o[0] pulses exactly once, 6 cycles after the write; busy_o[0] falls the same cycle.
REQ-034 AUDC0 fast pure, AUDF0=1; AUDC1=0x1AF (link), AUDF1=2 -> channel 1 borrows once per 3 channel-0 borrows (every 6 cycles).
REQ-035 Base tick, AUDF0=0, PRE=57 -> borrow0 once every 57 cycles; rst_i pulse mid-count -> count 0, audout 0 next cycle.
REQ-036 With POKEY_VOICE_HPF_EN: ch0 and ch2 same AUDF, hpf set -> ch_out0 constant 0; without the macro, the same stimulus toggles.

Source files
------------

// File: rtl/pokey_pkg.sv
// Shared constants for the POKEY-style voice bank: AUDC field positions,
// polynomial generator taps and register-select encodings.
package pokey_pkg;

  localparam int AUDC_W        = 12;
  localparam int AUDC_VOL_LSB  = 0;
  localparam int AUDC_VOL_MSB  = 3;
  localparam int AUDC_VOL_ONLY = 4;
  localparam int AUDC_PURE     = 5;
  localparam int AUDC_POLY4    = 6;
  localparam int AUDC_NO_POLY5 = 7;
  localparam int AUDC_LINK     = 8;
  localparam int AUDC_FAST     = 9;
  localparam int AUDC_ONESHOT  = 10;
  localparam int AUDC_HPF      = 11;

  localparam int POLY4_MSB  = 3;
  localparam int POLY4_TAP  = 2;
  localparam int POLY5_MSB  = 4;
  localparam int POLY5_TAP  = 2;
  localparam int POLY17_MSB = 16;
  localparam int POLY17_TAP = 11;

  typedef enum logic {
    SEL_AUDF = 1'b0,
    SEL_AUDC = 1'b1
  } reg_sel_e;

  // XNOR feedback keeps the all-zero reset state inside the sequence.
  function automatic logic xnor_fb(input logic a, input logic b);
    return ~(a ^ b);
  endfunction

endpackage

// File: rtl/pokey_voice.sv
// One voice channel: frequency counter, noise/tone flip-flop, one-shot and level.
// Optional high-pass stage enabled by macro POKEY_VOICE_HPF_EN.
module pokey_voice
  import pokey_pkg::*;
#(
  parameter int CW       = 8,
  parameter bit LINKABLE = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              link_borrow_i,
  input  logic              hp_clk_i,
  input  logic              poly4_i,
  input  logic              poly5_i,
  input  logic              poly17_i,
  input  logic              audf_we_i,
  input  logic              audc_we_i,
  input  logic [CW-1:0]     audf_i,
  input  logic [AUDC_W-1:0] audc_i,
  output logic [CW-1:0]     freq_o,
  output logic [AUDC_W-1:0] audc_o,
  output logic              borrow_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        level_o
);

`ifdef POKEY_VOICE_HPF_EN
  localparam logic [AUDC_W-1:0] AUDC_MASK = 12'hFFF;
`else
  localparam logic [AUDC_W-1:0] AUDC_MASK = 12'h7FF;
`endif

  logic [AUDC_W-1:0] audc_q, audc_d;
  logic [CW-1:0]     freq_q, freq_d;
  logic [CW-1:0]     count_q, count_d;
  logic              nf_q, nf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              en_s, borrow_s, nf_next_s, ch_out_s;
  logic              unused_link_s;

  assign unused_link_s = link_borrow_i & ~LINKABLE;

  // Clock enable source: fast beats link, link only honoured on odd channels.
  always_comb begin
    if (audc_q[AUDC_FAST]) begin
      en_s = 1'b1;
    end else if (LINKABLE && audc_q[AUDC_LINK]) begin
      en_s = link_borrow_i;
    end else begin
      en_s = tick_i;
    end
  end

  // A pending AUDF write swallows the borrow along with the decrement.
  assign borrow_s = en_s & busy_q & (count_q == {CW{1'b0}}) & ~audf_we_i;

  // Noise/tone source selected by the distortion bits.
  always_comb begin
    if (audc_q[AUDC_PURE]) begin
      nf_next_s = ~nf_q;
    end else if (audc_q[AUDC_POLY4]) begin
      nf_next_s = poly4_i;
    end else begin
      nf_next_s = poly17_i;
    end
  end

  // Next-state for counter, flip-flop, one-shot and control register.
  always_comb begin
    freq_d  = freq_q;
    count_d = count_q;
    nf_d    = nf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (audf_we_i) begin
      freq_d  = audf_i;
      count_d = audf_i;
      nf_d    = 1'b0;
      busy_d  = 1'b1;
    end else if (borrow_s) begin
      if (audc_q[AUDC_NO_POLY5] | poly5_i) begin
        nf_d = nf_next_s;
      end else begin
        nf_d = nf_q;
      end
      if (audc_q[AUDC_ONESHOT]) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        count_d = freq_q;
      end
    end else if (en_s & busy_q) begin
      count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
    if (audc_we_i) begin
      audc_d = audc_i & AUDC_MASK;
    end else begin
      audc_d = audc_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      audc_q  <= {AUDC_W{1'b0}};
      freq_q  <= {CW{1'b0}};
      count_q <= {CW{1'b0}};
      nf_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      audc_q  <= audc_d;
      freq_q  <= freq_d;
      count_q <= count_d;
      nf_q    <= nf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef POKEY_VOICE_HPF_EN
  logic hp_q, hp_d;

  // High-pass latch samples nf on the partner channel's borrow.
  always_comb begin
    if (!audc_q[AUDC_HPF]) begin
      hp_d = 1'b0;
    end else if (hp_clk_i) begin
      hp_d = nf_q;
    end else begin
      hp_d = hp_q;
    end
  end

  // High-pass latch register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hp_q <= 1'b0;
    end else begin
      hp_q <= hp_d;
    end
  end

  assign ch_out_s = audc_q[AUDC_HPF] ? (nf_q ^ hp_q) : nf_q;
`else
  logic unused_hpf_s;
  assign unused_hpf_s = hp_clk_i ^ audc_i[AUDC_HPF];
  assign ch_out_s     = nf_q;
`endif

  // Channel level into the mixer.
  always_comb begin
    if (audc_q[AUDC_VOL_ONLY] | ch_out_s) begin
      level_o = audc_q[AUDC_VOL_MSB:AUDC_VOL_LSB];
    end else begin
      level_o = 4'd0;
    end
  end

  assign freq_o   = freq_q;
  assign audc_o   = audc_q;
  assign borrow_o = borrow_s;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: rtl/pokey_voice_bank.sv
// Bank of NCH POKEY-style voices with shared prescaler, poly generators and mixer.
// Optional high-pass filtering enabled by macro POKEY_VOICE_HPF_EN.
module pokey_voice_bank
  import pokey_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 8,
  parameter int PRE = 57
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       we_i,
  input  logic [$clog2(NCH):0]       adr_i,
  input  logic [15:0]                dat_i,
  output logic [15:0]                dat_o,
  output logic [NCH-1:0]             busy_o,
  output logic [NCH-1:0]             done_o,
  output logic [4+$clog2(NCH)-1:0]   audout
);

  localparam int          CHW      = $clog2(NCH);
  localparam int          OW       = 4 + $clog2(NCH);
  localparam logic [7:0]  PRE_LAST = 8'(PRE - 1);

  logic [7:0]        presc_q, presc_d;
  logic [3:0]        p4_q, p4_d;
  logic [4:0]        p5_q, p5_d;
  logic [16:0]       p17_q, p17_d;
  logic [OW-1:0]     audout_q, mix_d;
  logic              tick_s;
  logic [CHW-1:0]    ch_s;
  reg_sel_e          sel_s;
  logic [NCH-1:0]    audf_we_s, audc_we_s, borrow_s, hp_clk_s;
  logic [NCH/2-1:0]  borrow_even_s, borrow_odd_s;
  logic [CW-1:0]     freq_s  [NCH];
  logic [AUDC_W-1:0] audc_s  [NCH];
  logic [3:0]        level_s [NCH];
  logic              unused_dat_s;

  assign unused_dat_s = ^dat_i[15:12];
  assign tick_s       = (presc_q == PRE_LAST);
  assign ch_s         = adr_i[CHW:1];
  assign sel_s        = reg_sel_e'(adr_i[0]);

  // Prescaler and shared polynomial generator next-state.
  always_comb begin
    if (tick_s) begin
      presc_d = 8'd0;
    end else begin
      presc_d = presc_q + 8'd1;
    end
    p4_d  = {p4_q[POLY4_MSB-1:0],   xnor_fb(p4_q[POLY4_MSB],   p4_q[POLY4_TAP])};
    p5_d  = {p5_q[POLY5_MSB-1:0],   xnor_fb(p5_q[POLY5_MSB],   p5_q[POLY5_TAP])};
    p17_d = {p17_q[POLY17_MSB-1:0], xnor_fb(p17_q[POLY17_MSB], p17_q[POLY17_TAP])};
  end

  // Register write decode.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      if (we_i && (ch_s == CHW'(i))) begin
        audf_we_s[i] = (sel_s == SEL_AUDF);
        audc_we_s[i] = (sel_s == SEL_AUDC);
      end else begin
        audf_we_s[i] = 1'b0;
        audc_we_s[i] = 1'b0;
      end
    end
  end

  // Even and odd borrows are kept apart so the link path is visibly acyclic.
  always_comb begin
    for (int k = 0; k < NCH/2; k++) begin
      borrow_s[2*k]   = borrow_even_s[k];
      borrow_s[2*k+1] = borrow_odd_s[k];
    end
  end

  assign hp_clk_s = borrow_s >> 2'd2;

  for (genvar k = 0; k < NCH/2; k++) begin : g_pair
    pokey_voice #(.CW(CW), .LINKABLE(1'b0)) u_even (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .tick_i        (tick_s),
      .link_borrow_i (1'b0),
      .hp_clk_i      (hp_clk_s[2*k]),
      .poly4_i       (p4_q[POLY4_MSB]),
      .poly5_i       (p5_q[POLY5_MSB]),
      .poly17_i      (p17_q[POLY17_MSB]),
      .audf_we_i     (audf_we_s[2*k]),
      .audc_we_i     (audc_we_s[2*k]),
      .audf_i        (dat_i[CW-1:0]),
      .audc_i        (dat_i[AUDC_W-1:0]),
      .freq_o        (freq_s[2*k]),
      .audc_o        (audc_s[2*k]),
      .borrow_o      (borrow_even_s[k]),
      .busy_o        (busy_o[2*k]),
      .done_o        (done_o[2*k]),
      .level_o       (level_s[2*k])
    );

    pokey_voice #(.CW(CW), .LINKABLE(1'b1)) u_odd (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .tick_i        (tick_s),
      .link_borrow_i (borrow_even_s[k]),
      .hp_clk_i      (hp_clk_s[2*k+1]),
      .poly4_i       (p4_q[POLY4_MSB]),
      .poly5_i       (p5_q[POLY5_MSB]),
      .poly17_i      (p17_q[POLY17_MSB]),
      .audf_we_i     (audf_we_s[2*k+1]),
      .audc_we_i     (audc_we_s[2*k+1]),
      .audf_i        (dat_i[CW-1:0]),
      .audc_i        (dat_i[AUDC_W-1:0]),
      .freq_o        (freq_s[2*k+1]),
      .audc_o        (audc_s[2*k+1]),
      .borrow_o      (borrow_odd_s[k]),
      .busy_o        (busy_o[2*k+1]),
      .done_o        (done_o[2*k+1]),
      .level_o       (level_s[2*k+1])
    );
  end

  // Mixer sum; output width covers NCH * 15 without saturation.
  always_comb begin
    mix_d = {OW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      mix_d = mix_d + OW'(level_s[i]);
    end
  end

  // Prescaler, polynomial generators and mixer output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q  <= 8'd0;
      p4_q     <= 4'd0;
      p5_q     <= 5'd0;
      p17_q    <= 17'd0;
      audout_q <= {OW{1'b0}};
    end else begin
      presc_q  <= presc_d;
      p4_q     <= p4_d;
      p5_q     <= p5_d;
      p17_q    <= p17_d;
      audout_q <= mix_d;
    end
  end

  assign audout = audout_q;

  // Zero-extended readback of the addressed register.
  always_comb begin
    dat_o = 16'd0;
    if (int'(ch_s) < NCH) begin
      case (sel_s)
        SEL_AUDF: dat_o[CW-1:0]     = freq_s[ch_s];
        SEL_AUDC: dat_o[AUDC_W-1:0] = audc_s[ch_s];
        default:  dat_o             = 16'd0;
      endcase
    end else begin
      dat_o = 16'd0;
    end
  end

endmodule

// File: tb/tb_pokey_voice_bank.sv
// Self-checking bench for pokey_voice_bank: directed scenarios plus random
// register traffic, all compared against a cycle-level behavioural model.
module tb_pokey_voice_bank;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PRE = 57;
  localparam int AW  = 3;
  localparam int OW  = 6;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          we_i;
  logic [AW-1:0] adr_i;
  logic [15:0]   dat_i;
  logic [15:0]   dat_o;
  logic [NCH-1:0] busy_o, done_o;
  logic [OW-1:0] audout;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  pokey_voice_bank #(.NCH(NCH), .CW(CW), .PRE(PRE)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (we_i),
    .adr_i  (adr_i),
    .dat_i  (dat_i),
    .dat_o  (dat_o),
    .busy_o (busy_o),
    .done_o (done_o),
    .audout (audout)
  );

  // ---------------- behavioural model ----------------
  int m_freq [NCH];
  int m_cnt  [NCH];
  int m_audc [NCH];
  int m_nf   [NCH];
  int m_busy [NCH];
  int m_done [NCH];
  int m_hp   [NCH];
  int m_presc, m_p4, m_p5, m_p17, m_aud;

`ifdef POKEY_VOICE_HPF_EN
  localparam int AUDC_KEEP = 'hFFF;
`else
  localparam int AUDC_KEEP = 'h7FF;
`endif

  function automatic int bitof(input int v, input int b);
    return (v >> b) & 1;
  endfunction

  function automatic int level(input int i);
    int co;
    co = m_nf[i];
`ifdef POKEY_VOICE_HPF_EN
    if (bitof(m_audc[i], 11) == 1) co = co ^ m_hp[i];
`endif
    if (bitof(m_audc[i], 4) == 1 || co == 1) return m_audc[i] & 15;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_freq[i] = 0; m_cnt[i] = 0; m_audc[i] = 0; m_nf[i] = 0;
      m_busy[i] = 0; m_done[i] = 0; m_hp[i] = 0;
    end
    m_presc = 0; m_p4 = 0; m_p5 = 0; m_p17 = 0; m_aud = 0;
  endtask

  task automatic model_step(input logic w, input logic [AW-1:0] a, input logic [15:0] d);
    int en [NCH];
    int br [NCH];
    int sum, ch, sel, tick, src, wf;
    tick = (m_presc == PRE - 1) ? 1 : 0;
    ch   = int'(a) >> 1;
    sel  = int'(a) & 1;
    for (int i = 0; i < NCH; i++) begin
      if (bitof(m_audc[i], 9) == 1)                       en[i] = 1;
      else if (bitof(m_audc[i], 8) == 1 && (i % 2) == 1)  en[i] = br[i-1];
      else                                                en[i] = tick;
      wf = (w && sel == 0 && ch == i) ? 1 : 0;
      br[i] = (en[i] == 1 && m_busy[i] == 1 && m_cnt[i] == 0 && wf == 0) ? 1 : 0;
    end
    sum = 0;
    for (int i = 0; i < NCH; i++) sum += level(i);
    for (int i = 0; i < NCH; i++) begin
      if (bitof(m_audc[i], 11) == 0) m_hp[i] = 0;
      else if (i + 2 < NCH && br[i+2] == 1) m_hp[i] = m_nf[i];
    end
    for (int i = 0; i < NCH; i++) begin
      m_done[i] = 0;
      if (w && sel == 0 && ch == i) begin
        m_freq[i] = int'(d) & 255; m_cnt[i] = m_freq[i]; m_nf[i] = 0; m_busy[i] = 1;
      end else if (br[i] == 1) begin
        if (bitof(m_audc[i], 7) == 1 || bitof(m_p5, 4) == 1) begin
          if (bitof(m_audc[i], 5) == 1)      src = 1 - m_nf[i];
          else if (bitof(m_audc[i], 6) == 1) src = bitof(m_p4, 3);
          else                               src = bitof(m_p17, 16);
          m_nf[i] = src;
        end
        if (bitof(m_audc[i], 10) == 1) begin
          m_busy[i] = 0; m_done[i] = 1;
        end else begin
          m_cnt[i] = m_freq[i];
        end
      end else if (en[i] == 1 && m_busy[i] == 1) begin
        m_cnt[i] = (m_cnt[i] - 1) & 255;
      end
      if (w && sel == 1 && ch == i) m_audc[i] = int'(d) & AUDC_KEEP;
    end
    m_p4  = ((m_p4  << 1) | (1 - (bitof(m_p4, 3)   ^ bitof(m_p4, 2))))   & 'hF;
    m_p5  = ((m_p5  << 1) | (1 - (bitof(m_p5, 4)   ^ bitof(m_p5, 2))))   & 'h1F;
    m_p17 = ((m_p17 << 1) | (1 - (bitof(m_p17, 16) ^ bitof(m_p17, 11)))) & 'h1FFFF;
    m_presc = (tick == 1) ? 0 : m_presc + 1;
    m_aud   = sum;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] eb, ed;
    int ch;
    for (int i = 0; i < NCH; i++) begin
      eb[i] = m_busy[i][0];
      ed[i] = m_done[i][0];
    end
    ch = int'(adr_i) >> 1;
    chk("audout", 32'(audout), 32'(m_aud));
    chk("busy",   32'(busy_o), 32'(eb));
    chk("done",   32'(done_o), 32'(ed));
    chk("dat_o",  32'(dat_o),  32'(adr_i[0] ? m_audc[ch] : m_freq[ch]));
  endtask

  task automatic tick_clk();
    @(posedge clk_i);
    if (rst_i) model_reset();
    else model_step(we_i, adr_i, dat_i);
    #1;
    check_all();
  endtask

  task automatic wr(input int a, input int d);
    we_i = 1'b1; adr_i = AW'(a); dat_i = 16'(d);
    tick_clk();
    we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick_clk();
  endtask

  task automatic do_reset();
    rst_i = 1'b1; we_i = 1'b0;
    #1;
    chk("rst_audout", 32'(audout), 32'd0);
    chk("rst_busy",   32'(busy_o), 32'd0);
    chk("rst_done",   32'(done_o), 32'd0);
    tick_clk();
    rst_i = 1'b0;
  endtask

  // Interval between the first two changes of audout, -1 if not seen in bound.
  task automatic measure(input int bound, output int per);
    logic [OW-1:0] prev;
    int first;
    per = -1; first = -1; prev = audout;
    for (int k = 1; k <= bound; k++) begin
      tick_clk();
      if (audout !== prev) begin
        if (first < 0) first = k;
        else if (per < 0) per = k - first;
        prev = audout;
      end
    end
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int per, first_k, pulses;
    logic [15:0] hpf_rb;
    we_i = 1'b0; adr_i = '0; dat_i = '0; rst_i = 1'b0;
    model_reset();

    do_reset();
    adr_i = 3'd1; #1;
    chk("rst_audc0", 32'(dat_o), 32'd0);

    // Volume-only mix of two channels.
    wr(1, 'h01F);
    wr(3, 'h018);
    tick_clk();
    chk("mix23", 32'(audout), 32'd23);
    adr_i = 3'd1; #1;
    chk("rb_audc0", 32'(dat_o), 32'h01F);
    wr(5, 'hFFF);
    adr_i = 3'd5; #1;
`ifdef POKEY_VOICE_HPF_EN
    hpf_rb = 16'hFFF;
`else
    hpf_rb = 16'h7FF;
`endif
    chk("rb_hpf", 32'(dat_o), 32'(hpf_rb));

    // Fast pure tone, AUDF=3: audout alternates 0/15 every 4 cycles.
    do_reset();
    wr(1, 'h2AF);
    wr(0, 3);
    for (int k = 1; k <= 16; k++) begin
      tick_clk();
      if (k >= 5) chk("tone4", 32'(audout), (((k - 5) / 4) % 2 == 0) ? 32'd15 : 32'd0);
    end

    // One-shot fast, AUDF=5: single done pulse 6 cycles after the write.
    do_reset();
    wr(1, 'h6AF);
    wr(0, 5);
    first_k = -1; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      tick_clk();
      if (k == 5) chk("os_busy_pre", 32'(busy_o[0]), 32'd1);
      if (done_o[0] === 1'b1) begin
        pulses++;
        if (first_k < 0) begin
          first_k = k;
          chk("os_busy_fall", 32'(busy_o[0]), 32'd0);
        end
      end
    end
    chk("os_at", 32'(first_k), 32'd6);
    chk("os_cnt", 32'(pulses), 32'd1);

    // Linked pair: channel 1 borrows every 6 cycles.
    do_reset();
    wr(1, 'h2A0);
    wr(0, 1);
    wr(3, 'h1AF);
    wr(2, 2);
    measure(40, per);
    chk("link_per", 32'(per), 32'd6);

    // Base tick, AUDF=0: one borrow per prescaler period.
    do_reset();
    wr(1, 'h0AF);
    wr(0, 0);
    measure(150, per);
    chk("tick_per", 32'(per), 32'(PRE));

    // Reset mid-count aborts a one-shot without a done pulse.
    do_reset();
    wr(1, 'h6AF);
    wr(0, 20);
    idle(5);
    chk("abort_busy_pre", 32'(busy_o[0]), 32'd1);
    rst_i = 1'b1; #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_audout", 32'(audout), 32'd0);
    tick_clk();
    rst_i = 1'b0;
    adr_i = 3'd0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick_clk();
      if (done_o[0] === 1'b1) pulses++;
    end
    chk("abort_nodone", 32'(pulses), 32'd0);

    // Random register traffic against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      we_i  = ($urandom_range(0, 5) == 0);
      adr_i = AW'($urandom_range(0, 2 * NCH - 1));
      if (adr_i[0]) dat_i = 16'($urandom_range(0, 65535));
      else          dat_i = 16'($urandom_range(0, 6));
      tick_clk();
    end
    we_i = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
